// File: rtl/max7219_pkg.sv
// ---------------------------------------------------------------------------
// max7219_pkg
// Shared definitions for the MAX7219-compatible SPI receiver:
//   - register address map (REG_NOOP .. REG_TEST)
//   - receive FSM state encoding
//   - Code-B font lookup used when digit decoding is compiled in
// ---------------------------------------------------------------------------
package max7219_pkg;

    localparam logic [3:0] REG_NOOP       = 4'h0;
    localparam logic [3:0] REG_DIGIT0     = 4'h1;
    localparam logic [3:0] REG_DIGIT7     = 4'h8;
    localparam logic [3:0] REG_DECODE     = 4'h9;
    localparam logic [3:0] REG_INTENSITY  = 4'hA;
    localparam logic [3:0] REG_SCAN_LIMIT = 4'hB;
    localparam logic [3:0] REG_SHUTDOWN   = 4'hC;
    localparam logic [3:0] REG_TEST       = 4'hF;

    localparam int BIT_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } rx_state_e;

    // Segment pattern {A,B,C,D,E,F,G} for a Code-B character.
    function automatic logic [6:0] code_b_font(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'h0: seg = 7'h7E;
            4'h1: seg = 7'h30;
            4'h2: seg = 7'h6D;
            4'h3: seg = 7'h79;
            4'h4: seg = 7'h33;
            4'h5: seg = 7'h5B;
            4'h6: seg = 7'h5F;
            4'h7: seg = 7'h70;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h7B;
            4'hA: seg = 7'h01;  // '-'
            4'hB: seg = 7'h4F;  // 'E'
            4'hC: seg = 7'h37;  // 'H'
            4'hD: seg = 7'h0E;  // 'L'
            4'hE: seg = 7'h67;  // 'P'
            default: seg = 7'h00;  // blank
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/max7219_rx_xclockd.sv
// ---------------------------------------------------------------------------
// xclockd
// Multi-stage flop synchronizer for asynchronous inputs.
// Ports:
//   clk_in   destination clock
//   init_n   asynchronous active-low reset (stages load RST_VAL)
//   async_i  asynchronous input bus (BUS_WIDTH)
//   sync_o   synchronized output, STAGES flops after async_i
// ---------------------------------------------------------------------------
module xclockd #(
    parameter int                   BUS_WIDTH = 1,
    parameter int                   STAGES    = 2,
    parameter logic [BUS_WIDTH-1:0] RST_VAL   = '0
) (
    input  logic                 clk_in,
    input  logic                 init_n,
    input  logic [BUS_WIDTH-1:0] async_i,
    output logic [BUS_WIDTH-1:0] sync_o
);

    logic [BUS_WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk_in or negedge init_n) begin
        if (!init_n) begin
            for (int i = 0; i < STAGES; i++) stage_q[i] <= RST_VAL;
        end else begin
            stage_q[0] <= async_i;
            for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign sync_o = stage_q[STAGES-1];

endmodule

// File: rtl/max7219_rx.sv
// ---------------------------------------------------------------------------
// max7219_rx
// MAX7219-compatible SPI receiver (display-chip end of the link).
// Oversamples SPI_CLK/SPI_MOSI/SPI_CS, shifts frames in MSB first, drives a
// daisy-chain SPI_DOUT and commits the last FRAME_BITS bits on CS rising edge.
// Ports:
//   clk_in, init_n            system clock, async active-low reset
//   SPI_CLK/SPI_MOSI/SPI_CS   serial link inputs (CPOL=0, CS active low)
//   SPI_DOUT                  shift-register MSB, updated on SPI_CLK fall
//   rd_addr/rd_data           digit read port (combinational)
//   decode_mode .. disp_test  control register outputs
//   frame_valid/frame_err     one-cycle commit / framing-error pulses
// Build option: MAX7219_RX_DECODE_EN enables Code-B decoding on rd_data.
// ---------------------------------------------------------------------------
module max7219_rx
    import max7219_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 16
) (
    input  logic       clk_in,
    input  logic       init_n,
    input  logic       SPI_CLK,
    input  logic       SPI_MOSI,
    input  logic       SPI_CS,
    output logic       SPI_DOUT,
    input  logic [2:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [7:0] decode_mode,
    output logic [3:0] intensity,
    output logic [2:0] scan_limit,
    output logic       shutdown_n,
    output logic       disp_test,
    output logic       frame_valid,
    output logic       frame_err
);

    localparam logic [BIT_CNT_W-1:0] FRAME_LEN = BIT_CNT_W'(FRAME_BITS);
    // Index order: 0 = SPI_CLK, 1 = SPI_MOSI, 2 = SPI_CS (idles high).
    localparam logic [2:0] SYNC_RST = 3'b100;

    // ---------------- input synchronizers and edge detection --------------
    logic [2:0] pin_raw;
    logic [2:0] pin_sync;
    logic [2:0] pin_prev_q;

    assign pin_raw = {SPI_CS, SPI_MOSI, SPI_CLK};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            xclockd #(
                .BUS_WIDTH (1),
                .STAGES    (SYNC_STAGES),
                .RST_VAL   (SYNC_RST[gi])
            ) u_sync (
                .clk_in  (clk_in),
                .init_n  (init_n),
                .async_i (pin_raw[gi]),
                .sync_o  (pin_sync[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk_in or negedge init_n) begin
        if (!init_n) pin_prev_q <= SYNC_RST;
        else         pin_prev_q <= pin_sync;
    end

    logic clk_rise, clk_fall, cs_rise, cs_fall, mosi;
    assign clk_rise = pin_sync[0] & ~pin_prev_q[0];
    assign clk_fall = ~pin_sync[0] & pin_prev_q[0];
    assign mosi     = pin_sync[1];
    assign cs_rise  = pin_sync[2] & ~pin_prev_q[2];
    assign cs_fall  = ~pin_sync[2] & pin_prev_q[2];

    // ---------------- receive FSM and shift register ----------------------
    rx_state_e               state_q, state_d;
    logic [FRAME_BITS-1:0]   sreg_q, sreg_d;
    logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                    dout_q, dout_d;
    logic                    cs_fall_pend_q, cs_fall_pend_d;

    always_comb begin
        state_d        = state_q;
        sreg_d         = sreg_q;
        bit_cnt_d      = bit_cnt_q;
        dout_d         = dout_q;
        cs_fall_pend_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall || cs_fall_pend_q) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = '0;
                end
            end
            ST_SHIFT: begin
                // A clock edge sampled together with CS rise is still shifted.
                if (clk_rise) begin
                    sreg_d = {sreg_q[FRAME_BITS-2:0], mosi};
                    if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + 1'b1;
                end
                if (clk_fall) dout_d = sreg_q[FRAME_BITS-1];
                if (cs_rise)  state_d = ST_LATCH;
            end
            ST_LATCH: begin
                state_d = ST_IDLE;
                // A new frame starting right after the commit must not be lost.
                cs_fall_pend_d = cs_fall;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge init_n) begin
        if (!init_n) begin
            state_q        <= ST_IDLE;
            sreg_q         <= '0;
            bit_cnt_q      <= '0;
            dout_q         <= 1'b0;
            cs_fall_pend_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            sreg_q         <= sreg_d;
            bit_cnt_q      <= bit_cnt_d;
            dout_q         <= dout_d;
            cs_fall_pend_q <= cs_fall_pend_d;
        end
    end

    assign SPI_DOUT = dout_q;

    // ---------------- commit decode ---------------------------------------
    logic       in_latch, commit_ok, commit_err;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;

    assign in_latch   = (state_q == ST_LATCH);
    assign commit_ok  = in_latch && (bit_cnt_q >= FRAME_LEN);
    assign commit_err = in_latch && ((bit_cnt_q < FRAME_LEN) ||
                                     ((bit_cnt_q % FRAME_LEN) != '0));
    assign wr_addr    = sreg_q[11:8];
    assign wr_data    = sreg_q[7:0];

    // Command nibble above the address is don't-care on this chip.
    logic unused_cmd;
    assign unused_cmd = ^sreg_q[FRAME_BITS-2:12];

    // ---------------- register file ----------------------------------------
    logic [7:0] digit_q [8];
    logic [7:0] decode_q;
    logic [3:0] intensity_q;
    logic [2:0] scan_limit_q;
    logic       shutdown_n_q, disp_test_q;
    logic       frame_valid_q, frame_err_q;

    always_ff @(posedge clk_in or negedge init_n) begin
        if (!init_n) begin
            for (int i = 0; i < 8; i++) digit_q[i] <= '0;
            decode_q      <= '0;
            intensity_q   <= '0;
            scan_limit_q  <= '0;
            shutdown_n_q  <= 1'b0;
            disp_test_q   <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            frame_valid_q <= commit_ok;
            frame_err_q   <= commit_err;
            if (commit_ok) begin
                case (wr_addr)
                    REG_NOOP:       ;
                    REG_DECODE:     decode_q     <= wr_data;
                    REG_INTENSITY:  intensity_q  <= wr_data[3:0];
                    REG_SCAN_LIMIT: scan_limit_q <= wr_data[2:0];
                    REG_SHUTDOWN:   shutdown_n_q <= wr_data[0];
                    REG_TEST:       disp_test_q  <= wr_data[0];
                    default: begin
                        if (wr_addr >= REG_DIGIT0 && wr_addr <= REG_DIGIT7)
                            digit_q[3'(wr_addr - REG_DIGIT0)] <= wr_data;
                    end
                endcase
            end
        end
    end

    assign decode_mode = decode_q;
    assign intensity   = intensity_q;
    assign scan_limit  = scan_limit_q;
    assign shutdown_n  = shutdown_n_q;
    assign disp_test   = disp_test_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;

    // ---------------- digit read port --------------------------------------
`ifdef MAX7219_RX_DECODE_EN
    logic [7:0] rd_raw;
    always_comb begin
        rd_raw = digit_q[rd_addr];
        if (decode_q[rd_addr]) rd_data = {rd_raw[7], code_b_font(rd_raw[3:0])};
        else                   rd_data = rd_raw;
    end
`else
    assign rd_data = digit_q[rd_addr];
`endif

endmodule

// File: tb/tb_max7219_rx.sv
module tb_max7219_rx;

    logic       clk_in   = 1'b0;
    logic       init_n   = 1'b0;
    logic       SPI_CLK  = 1'b0;
    logic       SPI_MOSI = 1'b0;
    logic       SPI_CS   = 1'b1;
    logic       SPI_DOUT;
    logic [2:0] rd_addr  = 3'd0;
    logic [7:0] rd_data, decode_mode;
    logic [3:0] intensity;
    logic [2:0] scan_limit;
    logic       shutdown_n, disp_test, frame_valid, frame_err;

    max7219_rx #(.SYNC_STAGES(2), .FRAME_BITS(16)) dut (
        .clk_in      (clk_in),
        .init_n      (init_n),
        .SPI_CLK     (SPI_CLK),
        .SPI_MOSI    (SPI_MOSI),
        .SPI_CS      (SPI_CS),
        .SPI_DOUT    (SPI_DOUT),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .decode_mode (decode_mode),
        .intensity   (intensity),
        .scan_limit  (scan_limit),
        .shutdown_n  (shutdown_n),
        .disp_test   (disp_test),
        .frame_valid (frame_valid),
        .frame_err   (frame_err)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad = 0;
    int valid_cnt = 0;
    logic dout_seen [64];
    // Scoreboard entries are {expect frame_valid, expect frame_err}.
    logic [1:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Commit pulses are popped against the scoreboard as they appear.
    always @(negedge clk_in) begin
        if (init_n && (frame_valid || frame_err)) begin
            if (frame_valid) valid_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {30'd0, frame_valid, frame_err}, 32'd0);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                chk("sb_frame_valid", {31'd0, frame_valid}, {31'd0, e[1]});
                chk("sb_frame_err",   {31'd0, frame_err},   {31'd0, e[0]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    // One SPI bit: MOSI setup, sample DOUT late in the low phase, then a clock pulse.
    task automatic spi_bit(input logic b, input int idx);
        SPI_MOSI = b;
        repeat (4) @(negedge clk_in);
        dout_seen[idx] = SPI_DOUT;
        SPI_CLK = 1'b1;
        repeat (4) @(negedge clk_in);
        SPI_CLK = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] data, input int n);
        for (int i = 0; i < n; i++) spi_bit(data[n-1-i], i);
    endtask

    task automatic cs_window(input logic [31:0] data, input int n);
        @(negedge clk_in);
        SPI_CS = 1'b0;
        repeat (4) @(negedge clk_in);
        send_bits(data, n);
        repeat (4) @(negedge clk_in);
        SPI_CS = 1'b1;
        repeat (12) @(negedge clk_in);
    endtask

    initial begin
        int v0;

        // 1: reset state
        repeat (5) @(negedge clk_in);
        chk("rst_shutdown_n",  {31'd0, shutdown_n}, 32'd0);
        chk("rst_intensity",   {28'd0, intensity}, 32'd0);
        chk("rst_scan_limit",  {29'd0, scan_limit}, 32'd0);
        chk("rst_decode",      {24'd0, decode_mode}, 32'd0);
        chk("rst_disp_test",   {31'd0, disp_test}, 32'd0);
        chk("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
        chk("rst_frame_err",   {31'd0, frame_err}, 32'd0);
        chk("rst_dout",        {31'd0, SPI_DOUT}, 32'd0);
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            #1;
            chk($sformatf("rst_digit%0d", a), {24'd0, rd_data}, 32'd0);
        end
        init_n = 1'b1;
        repeat (5) @(negedge clk_in);

        // 2: intensity frame with exact commit latency (SYNC_STAGES+2)
        exp_q.push_back(2'b10);
        @(negedge clk_in);
        SPI_CS = 1'b0;
        repeat (4) @(negedge clk_in);
        send_bits(32'h0A07, 16);
        repeat (4) @(negedge clk_in);
        SPI_CS = 1'b1;
        repeat (3) @(negedge clk_in);
        chk("lat_intensity_before", {28'd0, intensity}, 32'd0);
        chk("lat_valid_before",     {31'd0, frame_valid}, 32'd0);
        @(negedge clk_in);
        chk("lat_intensity_after",  {28'd0, intensity}, 32'h7);
        chk("lat_valid_after",      {31'd0, frame_valid}, 32'd1);
        repeat (10) @(negedge clk_in);
        chk("t2_frame_err", {31'd0, frame_err}, 32'd0);

        // 3: shutdown, decode mode, digits
        exp_q.push_back(2'b10); cs_window(32'h0C01, 16);
        exp_q.push_back(2'b10); cs_window(32'h0903, 16);
        exp_q.push_back(2'b10); cs_window(32'h0105, 16);
        exp_q.push_back(2'b10); cs_window(32'h020F, 16);
        chk("t3_shutdown_n", {31'd0, shutdown_n}, 32'd1);
        chk("t3_decode",     {24'd0, decode_mode}, 32'h03);
        rd_addr = 3'd0; #1;
`ifdef MAX7219_RX_DECODE_EN
        chk("t3_digit0", {24'd0, rd_data}, 32'h5B);
`else
        chk("t3_digit0", {24'd0, rd_data}, 32'h05);
`endif
        rd_addr = 3'd1; #1;
`ifdef MAX7219_RX_DECODE_EN
        chk("t3_digit1", {24'd0, rd_data}, 32'h00);
`else
        chk("t3_digit1", {24'd0, rd_data}, 32'h0F);
`endif

        // 4: daisy chain, 32 bits in one window
        exp_q.push_back(2'b10);
        cs_window({16'h0B02, 16'h0A0F}, 32);
        begin
            logic [15:0] fwd;
            fwd = 16'h0B02;
            for (int i = 0; i < 16; i++)
                chk($sformatf("t4_dout_bit%0d", 16 + i), {31'd0, dout_seen[16+i]}, {31'd0, fwd[15-i]});
        end
        chk("t4_intensity",  {28'd0, intensity}, 32'hF);
        chk("t4_scan_limit", {29'd0, scan_limit}, 32'd0);

        // 5: error frames
        exp_q.push_back(2'b01);
        cs_window(32'h155, 9);
        chk("t5_short_intensity",  {28'd0, intensity}, 32'hF);
        chk("t5_short_scan_limit", {29'd0, scan_limit}, 32'd0);
        exp_q.push_back(2'b11);
        cs_window(32'hA0B05, 20);
        chk("t5_long_scan_limit", {29'd0, scan_limit}, 32'd5);

        // 6: reset in the middle of a frame
        @(negedge clk_in);
        SPI_CS = 1'b0;
        repeat (4) @(negedge clk_in);
        send_bits(32'h0A, 8);
        init_n = 1'b0;
        SPI_CS = 1'b1;
        repeat (6) @(negedge clk_in);
        init_n = 1'b1;
        repeat (6) @(negedge clk_in);
        chk("t6_intensity_reset", {28'd0, intensity}, 32'd0);
        v0 = valid_cnt;
        exp_q.push_back(2'b10);
        cs_window(32'h0F01, 16);
        chk("t6_disp_test",   {31'd0, disp_test}, 32'd1);
        chk("t6_intensity",   {28'd0, intensity}, 32'd0);
        chk("t6_valid_count", 32'(valid_cnt - v0), 32'd1);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
